call_stack: RTL

Parametrised multi-level return-address stack that replaces the single-entry Stack register of the A09 datapath. It allows nested subroutine calls up to `Depth` levels. The sequence control matrix drives `Push` on a call, with `DIn` taken from the PC. It drives `Pop` on a return, and `DOut` feeds the return-address input of MUX_PC. The block provides occupancy status and sticky overflow/underflow error flags, which the control matrix uses to raise Halt.

---
 rtl/call_stack_if.sv | 29 ++
 rtl/call_stack.sv | 89 ++++++++
 2 files changed

// File: rtl/call_stack_if.sv
// Request/status bundle for the return-address stack: the control matrix drives
// Push/Pop/DIn/Err_Clr (master); the stack returns top entry, occupancy and error flags.
interface call_stack_if #(
    parameter int DataWidth = 16,
    parameter int Depth     = 8
);
    localparam int CountWidth = $clog2(Depth + 1);

    logic                  Push;
    logic                  Pop;
    logic [DataWidth-1:0]  DIn;
    logic                  Err_Clr;
    logic [DataWidth-1:0]  DOut;
    logic [CountWidth-1:0] Count;
    logic                  Empty;
    logic                  Full;
    logic                  Overflow;
    logic                  Underflow;

    modport master (
        output Push, Pop, DIn, Err_Clr,
        input  DOut, Count, Empty, Full, Overflow, Underflow
    );

    modport slave (
        input  Push, Pop, DIn, Err_Clr,
        output DOut, Count, Empty, Full, Overflow, Underflow
    );
endinterface

// File: rtl/call_stack.sv
// Multi-level return-address stack with occupancy status and sticky error flags.
// Define CALL_STACK_WRAP_EN for circular push-on-full; default drops pushes when full.
module call_stack #(
    parameter int DataWidth = 16,
    parameter int Depth     = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    call_stack_if.slave bus
);
    localparam int CountWidth = $clog2(Depth + 1);
    localparam int PtrWidth   = $clog2(Depth);

    logic [DataWidth-1:0]  mem [Depth];
    logic [PtrWidth-1:0]   tp, tp_nxt, wr_addr;
    logic [CountWidth-1:0] count, count_nxt;
    logic                  wr_en, ovf_set, unf_set;
    logic                  empty, full, overflow, underflow;

    assign empty = (count == '0);
    assign full  = (count == CountWidth'(Depth));

    always_comb begin
        tp_nxt    = tp;
        count_nxt = count;
        wr_en     = 1'b0;
        wr_addr   = tp + PtrWidth'(1);
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (bus.Push && bus.Pop) begin
            if (empty) begin
                tp_nxt    = tp + PtrWidth'(1);
                count_nxt = count + CountWidth'(1);
                wr_en     = 1'b1;
                unf_set   = 1'b1;
            end else begin
                // Call immediately after return: replace top in place.
                wr_addr = tp;
                wr_en   = 1'b1;
            end
        end else if (bus.Push) begin
            if (!full) begin
                tp_nxt    = tp + PtrWidth'(1);
                count_nxt = count + CountWidth'(1);
                wr_en     = 1'b1;
            end else begin
                ovf_set = 1'b1;
`ifdef CALL_STACK_WRAP_EN
                tp_nxt  = tp + PtrWidth'(1);
                wr_en   = 1'b1;
`endif
            end
        end else if (bus.Pop) begin
            if (empty) begin
                unf_set = 1'b1;
            end else begin
                tp_nxt    = tp - PtrWidth'(1);
                count_nxt = count - CountWidth'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            tp        <= tp_nxt;
            count     <= count_nxt;
            overflow  <= (overflow  & ~bus.Err_Clr) | ovf_set;
            underflow <= (underflow & ~bus.Err_Clr) | unf_set;
        end
    end

    // Contents need no reset; Empty masks stale entries on DOut.
    always_ff @(posedge Clk) begin
        if (wr_en && !Reset)
            mem[wr_addr] <= bus.DIn;
    end

    assign bus.DOut      = empty ? '0 : mem[tp];
    assign bus.Count     = count;
    assign bus.Empty     = empty;
    assign bus.Full      = full;
    assign bus.Overflow  = overflow;
    assign bus.Underflow = underflow;
endmodule
